// File: rtl/injection_monitor.sv
// Fault-injection checker: classifies each injection outcome and reports it.
// Optional INJ_MON_TIMESTAMP_EN adds a 32-bit cycle stamp (rpt_time).
module injection_monitor #(
  parameter int NOUT        = 2,
  parameter int PERSIST_CYC = 4,
  parameter int LAT_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             arm,
  input  logic             inj_strobe,
  input  logic [NOUT-1:0]  dut_y,
  input  logic [NOUT-1:0]  ref_y,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [1:0]       rpt_kind,
  output logic [NOUT-1:0]  rpt_mask,
  output logic [LAT_W-1:0] rpt_latency,
  output logic [CNT_W-1:0] err_count,
`ifdef INJ_MON_TIMESTAMP_EN
  output logic [31:0]      rpt_time,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_INJ,
    OBSERVE,
    REPORT
  } state_t;

  localparam logic [1:0] K_MASKED = 2'd0;
  localparam logic [1:0] K_TRANS  = 2'd1;
  localparam logic [1:0] K_PERS   = 2'd2;
  localparam logic [1:0] K_SPUR   = 2'd3;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] PERSIST = LAT_W'(PERSIST_CYC);

  state_t state, state_n;

  logic [NOUT-1:0]  diff;
  logic             mis;
  logic [LAT_W-1:0] lat_cnt, lat_n, lat_inc;
  logic [LAT_W-1:0] run_cnt, run_n, run_inc;
  logic [1:0]       kind_n;
  logic [NOUT-1:0]  mask_n;
  logic [LAT_W-1:0] lat_rep_n;
  logic [CNT_W-1:0] err_n;

  assign diff    = dut_y ^ ref_y;
  assign mis     = |diff;
  assign lat_inc = (lat_cnt == LAT_MAX) ? LAT_MAX : lat_cnt + LAT_W'(1);
  assign run_inc = run_cnt + LAT_W'(1);

  // a run is in progress once run_cnt is non-zero; its first clear ends it
  always_comb begin
    state_n   = state;
    lat_n     = lat_cnt;
    run_n     = run_cnt;
    kind_n    = rpt_kind;
    mask_n    = rpt_mask;
    lat_rep_n = rpt_latency;
    err_n     = err_count;
    unique case (state)
      IDLE: begin
        if (arm) state_n = WAIT_INJ;
      end
      WAIT_INJ: begin
        if (!arm) begin
          state_n = IDLE;
        end else if (inj_strobe) begin
          state_n   = OBSERVE;
          lat_n     = '0;
          lat_rep_n = '0;
          kind_n    = K_MASKED;
          mask_n    = diff;
          run_n     = mis ? LAT_W'(1) : '0;
          if (mis && PERSIST == LAT_W'(1)) begin
            state_n = REPORT;
            kind_n  = K_PERS;
          end
        end else if (mis) begin
          state_n   = REPORT;
          kind_n    = K_SPUR;
          mask_n    = diff;
          lat_rep_n = '0;
        end
      end
      OBSERVE: begin
        if (!arm) begin
          state_n = IDLE;
        end else begin
          lat_n = lat_inc;
          if (mis) begin
            run_n  = run_inc;
            mask_n = rpt_mask | diff;
            if (run_cnt == '0) lat_rep_n = lat_inc;
            if (run_inc == PERSIST) begin
              state_n = REPORT;
              kind_n  = K_PERS;
            end
          end else if (run_cnt != '0) begin
            state_n = REPORT;
            kind_n  = K_TRANS;
          end else if (lat_inc == LAT_MAX) begin
            state_n   = REPORT;
            kind_n    = K_MASKED;
            mask_n    = '0;
            lat_rep_n = LAT_MAX;
          end
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          state_n = arm ? WAIT_INJ : IDLE;
          if (rpt_kind != K_MASKED && err_count != '1)
            err_n = err_count + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      run_cnt     <= '0;
      rpt_kind    <= '0;
      rpt_mask    <= '0;
      rpt_latency <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      lat_cnt     <= lat_n;
      run_cnt     <= run_n;
      rpt_kind    <= kind_n;
      rpt_mask    <= mask_n;
      rpt_latency <= lat_rep_n;
      err_count   <= err_n;
    end
  end

  assign rpt_valid = (state == REPORT);
  assign busy      = (state != IDLE);

`ifdef INJ_MON_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts       <= '0;
      rpt_time <= '0;
    end else begin
      ts <= ts + 32'd1;
      if (state != REPORT && state_n == REPORT) rpt_time <= ts;
    end
  end
`endif

endmodule

// File: tb/tb_injection_monitor.sv
// Bench for injection_monitor: directed plan steps plus random injections
// checked against a scan-based outcome model.
module tb_injection_monitor;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        arm;
  logic        inj_strobe;
  logic [1:0]  dut_y;
  logic [1:0]  ref_y;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [1:0]  rpt_kind;
  logic [1:0]  rpt_mask;
  logic [7:0]  rpt_latency;
  logic [15:0] err_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;

  logic [1:0] dseq [0:511];
  int e_kind, e_lat, e_mask, e_edge;

  injection_monitor #(
    .NOUT(2), .PERSIST_CYC(P), .LAT_W(8), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .arm        (arm),
    .inj_strobe (inj_strobe),
    .dut_y      (dut_y),
    .ref_y      (ref_y),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_kind   (rpt_kind),
    .rpt_mask   (rpt_mask),
    .rpt_latency(rpt_latency),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input logic [1:0] d);
    ref_y = 2'($urandom);
    dut_y = ref_y ^ d;
  endtask

  task automatic clr();
    for (int i = 0; i < 512; i++) dseq[i] = 2'b00;
  endtask

  // outcome from the diff trace: step 0 is the strobe cycle
  task automatic model();
    int k, run, m;
    k = -1;
    for (int i = 0; i <= 255; i++)
      if (k < 0 && dseq[i] != 2'b00) k = i;
    if (k < 0) begin
      e_kind = 0; e_lat = 255; e_mask = 0; e_edge = 255;
    end else begin
      run = 0;
      m = 0;
      while (run < P && dseq[k+run] != 2'b00) begin
        m = m | int'(dseq[k+run]);
        run++;
      end
      e_lat  = k;
      e_mask = m;
      if (run == P) begin
        e_kind = 2; e_edge = k + P - 1;
      end else begin
        e_kind = 1; e_edge = k + run;
      end
    end
  endtask

  task automatic inject(input string tag, input int hold);
    int got, obs_edge;
    model();
    got = 0;
    obs_edge = -1;
    for (int i = 0; i < 400 && got == 0; i++) begin
      inj_strobe = (i == 0);
      set_y(dseq[i]);
      tick();
      if (rpt_valid) begin
        got = 1;
        obs_edge = i;
      end
    end
    inj_strobe = 1'b0;
    set_y(2'b00);
    chk({tag, "_edge"}, obs_edge, e_edge);
    chk({tag, "_kind"}, rpt_kind, e_kind);
    chk({tag, "_lat"}, rpt_latency, e_lat);
    chk({tag, "_mask"}, rpt_mask, e_mask);
    for (int i = 0; i < hold; i++) begin
      inj_strobe = 1'($urandom_range(0, 1));
      set_y(2'($urandom));
      tick();
      chk({tag, "_hold_valid"}, rpt_valid, 1);
      chk({tag, "_hold_kind"}, rpt_kind, e_kind);
      chk({tag, "_hold_lat"}, rpt_latency, e_lat);
      chk({tag, "_hold_mask"}, rpt_mask, e_mask);
    end
    inj_strobe = 1'b0;
    set_y(2'b00);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    if (e_kind != 0) err_exp++;
    chk({tag, "_ack_valid"}, rpt_valid, 0);
    chk({tag, "_ack_err"}, err_count, err_exp);
    chk({tag, "_ack_busy"}, busy, 1);
  endtask

  initial begin
    int k, run;
    rstn = 1'b0;
    arm = 1'b0;
    inj_strobe = 1'b0;
    rpt_ready = 1'b0;
    ref_y = 2'b00;
    dut_y = 2'b00;
    #90;
    chk("rst_valid", rpt_valid, 0);
    chk("rst_err", err_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_kind", rpt_kind, 0);
    chk("rst_mask", rpt_mask, 0);
    chk("rst_lat", rpt_latency, 0);
    rstn = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    arm = 1'b1;
    tick();
    chk("arm_busy", busy, 1);

    clr();
    dseq[3] = 2'b01;
    dseq[4] = 2'b01;
    inject("transient", 0);

    clr();
    dseq[1] = 2'b10;
    for (int i = 2; i < 40; i++) dseq[i] = 2'b11;
    inject("persist", 0);

    clr();
    inject("masked", 0);

    set_y(2'b01);
    tick();
    chk("spur_valid", rpt_valid, 1);
    chk("spur_kind", rpt_kind, 3);
    chk("spur_lat", rpt_latency, 0);
    chk("spur_mask", rpt_mask, 1);
    set_y(2'b00);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    err_exp++;
    chk("spur_err", err_count, err_exp);

    clr();
    dseq[0] = 2'b10;
    dseq[1] = 2'b01;
    inject("strobe_diff", 10);

    inj_strobe = 1'b1;
    set_y(2'b00);
    tick();
    inj_strobe = 1'b0;
    tick();
    set_y(2'b01);
    tick();
    arm = 1'b0;
    tick();
    chk("drop_busy", busy, 0);
    chk("drop_valid", rpt_valid, 0);
    repeat (3) begin
      set_y(2'($urandom));
      tick();
      chk("drop_quiet", rpt_valid, 0);
    end
    chk("drop_err", err_count, err_exp);
    set_y(2'b00);
    arm = 1'b1;
    tick();
    chk("rearm_busy", busy, 1);

    for (int r = 0; r < 10; r++) begin
      clr();
      if ($urandom_range(0, 7) != 0) begin
        k = $urandom_range(0, 30);
        run = $urandom_range(1, 6);
        for (int j = 0; j < run; j++) dseq[k+j] = 2'($urandom_range(1, 3));
      end
      inject("rand", $urandom_range(0, 3));
    end

    inj_strobe = 1'b1;
    tick();
    inj_strobe = 1'b0;
    set_y(2'b01);
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_err", err_count, 0);
    chk("arst_mask", rpt_mask, 0);
    chk("arst_valid", rpt_valid, 0);
    rstn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/injection_monitor.md
Name: injection_monitor

Overview:
- Checker end of the fault-injection path: watches DUT outputs against a golden reference copy after each injection strobe.
- Classifies each injection outcome as MASKED, TRANSIENT, PERSISTENT or SPURIOUS, measures fault latency, and hands one report per injection to a logger via valid/ready.
- Sits beside the injection module in the validation harness. Fed by the same clock and reset.

Parameters:
- NOUT, 2, number of monitored output bits (y1, y2 by default).
- PERSIST_CYC, 4, consecutive mismatching samples that make a fault PERSISTENT; legal range 1 to 2^LAT_W-1.
- LAT_W, 8, latency counter width; observation window is 2^LAT_W-1 cycles.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- arm  in  1  level; monitoring enabled while high.
- inj_strobe  in  1  one-cycle pulse marking the cycle a fault is injected.
- dut_y  in  NOUT  outputs of the fault-injected DUT.
- ref_y  in  NOUT  outputs of the golden copy.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts report.
- rpt_kind  out  2  0 MASKED, 1 TRANSIENT, 2 PERSISTENT, 3 SPURIOUS.
- rpt_mask  out  NOUT  OR of all diff bits seen during the mismatch run.
- rpt_latency  out  LAT_W  cycles from strobe to first mismatch; window length if MASKED.
- err_count  out  CNT_W  accepted reports with kind != 0, saturating.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: IDLE; rpt_valid=0, rpt_kind=0, rpt_mask=0, rpt_latency=0, err_count=0, busy=0; internal counters cleared.
- diff = dut_y ^ ref_y, evaluated combinationally each cycle. Mismatch means diff != 0.
- Latency definition: number of rising edges between the edge that samples inj_strobe=1 and the edge that samples the first mismatch.
- FSM states: IDLE, WAIT_INJ, OBSERVE, REPORT.
- IDLE: arm=1 -> WAIT_INJ.
- WAIT_INJ:
  - arm=0 -> IDLE.
  - inj_strobe=1 -> OBSERVE, lat_cnt=0.
  - If diff != 0 in the strobe cycle itself, that counts as a mismatch with latency 0; the strobe wins over SPURIOUS.
  - diff != 0 with no strobe -> REPORT, kind=3, mask=diff, latency=0.
- OBSERVE: lat_cnt increments each cycle; run_cnt counts consecutive mismatch samples; mask accumulates.
  - First mismatch: latency = lat_cnt.
  - run_cnt reaches PERSIST_CYC -> REPORT, kind=2.
  - Mismatch clears before PERSIST_CYC -> REPORT, kind=1, on that clearing edge.
  - lat_cnt reaches 2^LAT_W-1 with no mismatch seen -> REPORT, kind=0, latency=2^LAT_W-1, mask=0.
  - arm=0 -> IDLE immediately. No report, no err_count change.
  - inj_strobe ignored.
- REPORT:
  - rpt_valid=1 from the edge entering REPORT.
  - rpt_kind, rpt_mask and rpt_latency are registered and stay stable until handshake.
  - On rpt_valid && rpt_ready: rpt_valid drops next cycle; err_count increments if kind != 0 (saturates at all-ones).
  - Next state after handshake: WAIT_INJ if arm=1, else IDLE.
  - arm=0 does not cancel a pending report.
  - inj_strobe in REPORT is ignored.
- Maximum rate: one report per injection; back-to-back strobes while busy are dropped.
- Asynchronous reset mid-operation: immediate return to reset values; any pending report is lost.

Optional Feature:
- Macro: INJ_MON_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter (reset 0, wraps).
  - Adds output rpt_time (32 bits), which captures the counter on the edge entering REPORT and is held with the other report fields.
- Undefined: no counter and no rpt_time port; all other behaviour identical.

Test Plan:
- Reset for 90 ns with arm=0 -> rpt_valid=0, err_count=0, busy=0; after release, busy stays 0 until arm=1.
- arm=1, strobe at edge T, dut_y^ref_y=2'b01 at edges T+3 and T+4, clear at T+5 -> rpt_kind=1, rpt_latency=3, rpt_mask=2'b01; after ready, err_count=1.
- arm=1, strobe at T, diff 2'b10 at T+1 and 2'b11 from T+2 onward -> rpt_kind=2, rpt_latency=1, rpt_mask=2'b11, rpt_valid rises at edge T+4.
- arm=1, strobe, no diff for 255 cycles -> rpt_kind=0, rpt_latency=255, rpt_mask=0; err_count unchanged.
- arm=1, diff=2'b01 before any strobe -> rpt_kind=3, rpt_latency=0, rpt_mask=2'b01.
- Hold rpt_ready=0 for 10 cycles during REPORT -> fields stable, rpt_valid held. Separately, drop arm mid-OBSERVE -> IDLE, no report, err_count unchanged.
